layer_visibility_ctrl: RTL
==========================

// Module: layer_visibility_ctrl
// PURPOSE
//  Frame-synchronous controller that sequences which drawing layers may reach the priority
//  RGB mux. Gates the player, heart and endgame drawing requests per game phase:
//  player blink after a hit, end-screen delay, end-screen show and restart.
//  Sits between the object drawers and the RGB mux. Request gating is combinational;
//  the enable flags that control it are registered.
// PARAMETERS
//  BLINK_FRAMES    60  frames the player blinks (invulnerable) after a hit
//  BLINK_HALF      4   frames per blink half-period (visible/hidden)
//  END_DELAY       30  frames between gameOver and the endgame layer appearing
//  CNT_W           8   frame counter width; must hold max(BLINK_FRAMES, END_DELAY)
// PORTS
//  clk                    in   1  system clock
//  resetN                 in   1  async active-low reset
//  startOfFrame           in   1  one-cycle pulse at frame start
//  playerHit              in   1  one-cycle hit pulse
//  gameOver               in   1  one-cycle game-over pulse
//  restart                in   1  one-cycle restart pulse
//  playerDrawingReqIn     in   1  raw player request
//  heartDrawingReqIn      in   1  raw heart request
//  endgameDrawingReqIn    in   1  raw endgame request
//  playerDrawingRequest   out  1  playerDrawingReqIn & playerEn
//  heartDrawingRequest    out  1  heartDrawingReqIn & heartEn
//  endgameDrawingRequest  out  1  endgameDrawingReqIn & endgameEn
//  invulnerable           out  1  high in HIT_BLINK (state-derived, immediate)
//  phase                  out  2  current state encoding (phase_t)
// BEHAVIOUR
//  - One clock domain: clk. Reset is asynchronous and active-low (resetN).
//  - Reset values: state=PLAY, cnt=0, blinkCnt=0, blinkPhase=0.
//    Enables at reset: playerEn=1, heartEn=1, endgameEn=0.
//    Output values at reset: invulnerable=0, phase=PLAY.
//  - States:
//    - PLAY: playerEn=1, heartEn=1, endgameEn=0.
//    - HIT_BLINK: playerEn=~blinkPhase, heartEn=1, endgameEn=0.
//    - END_DELAY: playerEn=1, heartEn=0, endgameEn=0.
//    - END_SHOW: playerEn=0, heartEn=0, endgameEn=1.
//  - Transition priority each cycle: restart > gameOver > playerHit > frame count.
//  - restart: in any state, go to PLAY next cycle and clear cnt/blinkCnt/blinkPhase.
//  - gameOver:
//    - In PLAY or HIT_BLINK: go to END_DELAY and set cnt=0.
//    - In END_DELAY or END_SHOW: ignored.
//  - playerHit:
//    - In PLAY: go to HIT_BLINK; set cnt=0, blinkCnt=0, blinkPhase=0.
//    - Otherwise ignored; a re-hit does not extend the blink.
//  - HIT_BLINK, on startOfFrame (not the entry cycle):
//    - cnt++.
//    - blinkCnt++; when blinkCnt==BLINK_HALF-1, wrap blinkCnt to 0 and toggle blinkPhase.
//    - When cnt==BLINK_FRAMES-1: go to PLAY.
//  - END_DELAY, on startOfFrame: cnt++; when cnt==END_DELAY-1, go to END_SHOW.
//  - END_SHOW: held until restart.
//  - Enables are registered and load only on a startOfFrame cycle, from next-state values.
//    This avoids mid-frame tearing. Until the next SOF, the old enables persist.
//    This also holds after restart.
//  - Event coinciding with SOF: the transition is taken, and the enables load the
//    new state's values in that same SOF.
//  - Counters are unsigned CNT_W. They never wrap in legal use; saturate at all-ones.
// CONFIGURATION
//  - LAYER_CTRL_HIT_FREEZE_EN defined:
//    - Adds input freezeFrames (1 bit).
//    - While freezeFrames=1, SOF does not advance cnt/blinkCnt in HIT_BLINK or END_DELAY.
//      Enables still reload at SOF.
//  - LAYER_CTRL_HIT_FREEZE_EN undefined: no freeze port; counters always advance on SOF.
// STRUCTURE
//  - layer_ctrl_pkg holds:
//    - typedef enum logic[1:0] phase_t {PLAY, HIT_BLINK, END_DELAY, END_SHOW}.
//    - typedef struct packed layer_en_t {player, heart, endgame}.
//    - Function en_for(phase_t, blinkPhase) returning layer_en_t.
//  - Sub-module frame_tick_counter: counts SOF pulses, with clear, enable and
//    terminal-count compare. Used for both cnt and blinkCnt.
// TESTING (BLINK_FRAMES=6, BLINK_HALF=2, END_DELAY=3)
//  1. Reset, SOF, all ReqIn=1:
//     -> player=1, heart=1, endgame=0; phase=PLAY; invulnerable=0.
//  2. playerHit mid-frame:
//     -> invulnerable=1 next cycle; player stays 1 until next SOF.
//     -> Then player per SOF: 1,1,0,0,1,1; PLAY after 6th SOF, invulnerable=0.
//  3. playerHit again at the 3rd frame of blink -> ignored; blink ends at the same SOF as test 2.
//  4. gameOver same cycle as playerHit -> END_DELAY (not HIT_BLINK).
//     -> At SOF, heart=0; endgame=1 after the 3rd subsequent SOF; phase=END_SHOW.
//  5. restart in END_SHOW:
//     -> phase=PLAY next cycle; endgame stays 1 until next SOF, then 0.
//     -> player=1, heart=1.
//  6. resetN low mid-HIT_BLINK -> immediate PLAY, enables 1/1/0, counters 0;
//     with LAYER_CTRL_HIT_FREEZE_EN and freezeFrames=1 in HIT_BLINK -> blink pattern holds.

Source files
------------

// File: rtl/layer_ctrl_pkg.sv
// Shared types for the layer visibility controller: game phase encoding,
// per-layer enable flags and the phase-to-enable decode.
package layer_ctrl_pkg;

  typedef enum logic [1:0] {
    PLAY      = 2'd0,
    HIT_BLINK = 2'd1,
    END_DELAY = 2'd2,
    END_SHOW  = 2'd3
  } phase_t;

  typedef struct packed {
    logic player;
    logic heart;
    logic endgame;
  } layer_en_t;

  localparam layer_en_t EN_RESET = '{player: 1'b1, heart: 1'b1, endgame: 1'b0};

  function automatic layer_en_t en_for(input phase_t ph, input logic blink_phase);
    layer_en_t en;
    case (ph)
      PLAY:      en = EN_RESET;
      HIT_BLINK: en = '{player: ~blink_phase, heart: 1'b1, endgame: 1'b0};
      END_DELAY: en = '{player: 1'b1, heart: 1'b0, endgame: 1'b0};
      END_SHOW:  en = '{player: 1'b0, heart: 1'b0, endgame: 1'b1};
      default:   en = EN_RESET;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/frame_tick_counter.sv
// Saturating start-of-frame counter with synchronous clear, increment enable,
// terminal-count compare and optional wrap to zero at terminal count.
module frame_tick_counter #(
  parameter int CNT_W = 8,
  parameter bit WRAP  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [CNT_W-1:0] term_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == term_i);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      if (WRAP && tc_o) begin
        cnt_d = '0;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/layer_visibility_ctrl.sv
// Frame-synchronous gating of player/heart/endgame drawing requests by game phase.
// Optional LAYER_CTRL_HIT_FREEZE_EN adds freezeFrames to pause the frame counters.
module layer_visibility_ctrl #(
  parameter int BLINK_FRAMES = 60,
  parameter int BLINK_HALF   = 4,
  parameter int END_DELAY    = 30,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       playerHit,
  input  logic       gameOver,
  input  logic       restart,
`ifdef LAYER_CTRL_HIT_FREEZE_EN
  input  logic       freezeFrames,
`endif
  input  logic       playerDrawingReqIn,
  input  logic       heartDrawingReqIn,
  input  logic       endgameDrawingReqIn,
  output logic       playerDrawingRequest,
  output logic       heartDrawingRequest,
  output logic       endgameDrawingRequest,
  output logic       invulnerable,
  output logic [1:0] phase
);

  import layer_ctrl_pkg::*;

  phase_t     state_q, state_d;
  logic       blink_phase_q, blink_phase_d;
  layer_en_t  en_q;
  logic       advance, go_take, hit_take, blink_inc, delay_inc;
  logic       cnt_clr, blink_clr, cnt_tc, blink_tc, en_blink_phase;
  logic [CNT_W-1:0] cnt_term;

`ifdef LAYER_CTRL_HIT_FREEZE_EN
  assign advance = startOfFrame & ~freezeFrames;
  // A frozen frame repeats whatever blink half is currently on screen.
  assign en_blink_phase = blink_clr ? 1'b0 :
                          (freezeFrames && state_q == HIT_BLINK) ? ~en_q.player :
                          blink_phase_q;
`else
  assign advance        = startOfFrame;
  assign en_blink_phase = blink_clr ? 1'b0 : blink_phase_q;
`endif

  assign go_take   = gameOver & (state_q == PLAY || state_q == HIT_BLINK);
  assign hit_take  = playerHit & (state_q == PLAY);
  assign blink_inc = ~restart & ~go_take & advance & (state_q == HIT_BLINK);
  assign delay_inc = ~restart & advance & (state_q == layer_ctrl_pkg::END_DELAY);
  assign cnt_clr   = restart | go_take | hit_take;
  assign blink_clr = restart | hit_take;
  assign cnt_term  = (state_q == HIT_BLINK) ? CNT_W'(BLINK_FRAMES - 1) : CNT_W'(END_DELAY - 1);

  frame_tick_counter #(.CNT_W(CNT_W), .WRAP(1'b0)) u_frame_cnt (
    .clk   (clk),
    .rst_n (resetN),
    .clr_i (cnt_clr),
    .inc_i (blink_inc | delay_inc),
    .term_i(cnt_term),
    .tc_o  (cnt_tc)
  );

  frame_tick_counter #(.CNT_W(CNT_W), .WRAP(1'b1)) u_blink_cnt (
    .clk   (clk),
    .rst_n (resetN),
    .clr_i (blink_clr),
    .inc_i (blink_inc),
    .term_i(CNT_W'(BLINK_HALF - 1)),
    .tc_o  (blink_tc)
  );

  always_comb begin
    state_d       = state_q;
    blink_phase_d = blink_phase_q;
    if (restart) begin
      state_d       = PLAY;
      blink_phase_d = 1'b0;
    end else if (go_take) begin
      state_d = layer_ctrl_pkg::END_DELAY;
    end else if (hit_take) begin
      state_d       = HIT_BLINK;
      blink_phase_d = 1'b0;
    end else if (blink_inc) begin
      if (blink_tc) blink_phase_d = ~blink_phase_q;
      if (cnt_tc)   state_d       = PLAY;
    end else if (delay_inc && cnt_tc) begin
      state_d = END_SHOW;
    end
  end

  // Enables reload only at frame start so a layer never tears mid-frame; the blink
  // half shown for the coming frame is the one in force before this SOF's toggle.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= PLAY;
      blink_phase_q <= 1'b0;
      en_q          <= EN_RESET;
    end else begin
      state_q       <= state_d;
      blink_phase_q <= blink_phase_d;
      if (startOfFrame) en_q <= en_for(state_d, en_blink_phase);
    end
  end

  assign playerDrawingRequest  = playerDrawingReqIn  & en_q.player;
  assign heartDrawingRequest   = heartDrawingReqIn   & en_q.heart;
  assign endgameDrawingRequest = endgameDrawingReqIn & en_q.endgame;
  assign invulnerable          = (state_q == HIT_BLINK);
  assign phase                 = state_q;

endmodule
